// File: rtl/rr_mux_arbiter_4_pkg.sv
// rtl/rr_mux_arbiter_4_pkg.sv - shared types and sizes for the round-robin mux arbiter
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0]       req_idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_mux_arbiter_4_if.sv
// rtl/rr_mux_arbiter_4_if.sv - requester and output channel bundle for the arbiter
interface rr_mux_arbiter_4_if #(
  parameter int WIDTH = 4
);
  import rr_arb_pkg::*;

  req_vec_t                 in_valid;
  logic [N_REQ*WIDTH-1:0]   in_data;
  req_vec_t                 in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  req_idx_t                 out_src;
  logic                     out_ready;

  // Arbiter side: consumes requests, produces the registered output channel.
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  // Environment side: four producers plus the downstream consumer.
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_mux_arbiter_4_pick.sv
// rtl/rr_mux_arbiter_4_pick.sv - combinational rotating-priority picker
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  req_vec_t valid,
  input  req_idx_t ptr,
  output req_vec_t grant,
  output req_idx_t idx,
  output logic     any_grant
);

  req_idx_t cand;

  // Walk the search order backwards so the requester closest to ptr wins last.
  always_comb begin
    grant     = '0;
    idx       = ptr;
    any_grant = 1'b0;
    cand      = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + k[1:0];
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rtl/rr_mux_arbiter_4.sv - four-way round-robin arbiter feeding one registered output word
module rr_mux_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_4_if.master bus
);

  req_idx_t         ptr;
  req_vec_t         grant;
  req_idx_t         gidx;
  logic             any_grant;
  logic             can_load;
  logic             transfer;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  req_idx_t         out_src_q;
  logic [WIDTH-1:0] sel_data;

  rr_pick_4 u_pick (
    .valid     (bus.in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .idx       (gidx),
    .any_grant (any_grant)
  );

  // The register can accept a word when empty or when its word leaves this cycle;
  // ready is held low while reset is asserted.
  assign can_load     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (can_load && rst_n) ? grant : '0;
  assign transfer     = any_grant && can_load && rst_n;

  // Data mux steered by the granted index only; in_data never reaches in_ready.
  always_comb begin
    sel_data = bus.in_data[WIDTH-1:0];
    case (gidx)
      2'd0: sel_data = bus.in_data[0*WIDTH +: WIDTH];
      2'd1: sel_data = bus.in_data[1*WIDTH +: WIDTH];
      2'd2: sel_data = bus.in_data[2*WIDTH +: WIDTH];
      2'd3: sel_data = bus.in_data[3*WIDTH +: WIDTH];
    endcase
  end

  // Output word, source tag and priority pointer; ptr moves only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr         <= '0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_src_q   <= gidx;
      ptr         <= gidx + 2'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb/tb_rr_mux_arbiter_4.sv - directed scoreboard bench for rr_mux_arbiter_4
module tb_rr_mux_arbiter_4;
  import rr_arb_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_mux_arbiter_4_if #(.WIDTH(WIDTH)) bus ();

  rr_mux_arbiter_4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [WIDTH+1:0] sb[$];
  logic [WIDTH-1:0] last_data;
  req_idx_t         last_src;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs already driven. Checks the expected ready
  // vector, pushes the word that should transfer, clocks once and pops it.
  task automatic step(input string tag, input req_vec_t exp_ready);
    logic [WIDTH+1:0] e;
    int idx;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    idx = -1;
    for (int i = 0; i < N_REQ; i++)
      if (exp_ready[i] && bus.in_valid[i]) idx = i;
    if (idx >= 0) sb.push_back({idx[1:0], bus.in_data[idx*WIDTH +: WIDTH]});
    @(posedge clk);
    @(negedge clk);
    if (idx >= 0) begin
      e = sb.pop_front();
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".out_data"},  32'(bus.out_data),  32'(e[WIDTH-1:0]));
      chk({tag, ".out_src"},   32'(bus.out_src),   32'(e[WIDTH+1:WIDTH]));
      last_data = e[WIDTH-1:0];
      last_src  = e[WIDTH+1:WIDTH];
    end
  endtask

  initial begin
    last_data = '0;
    last_src  = '0;
    bus.in_valid  = 4'hf;
    bus.in_data   = 16'hdcba;
    bus.out_ready = 1'b1;

    // Reset state, with requests already pending.
    @(negedge clk);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_data",  32'(bus.out_data),  32'd0);
    chk("rst.out_src",   32'(bus.out_src),   32'd0);
    rst_n = 1'b1;

    // All valid, fair rotation a/0 b/1 c/2 d/3 a/0.
    step("rr0", 4'b0001);
    step("rr1", 4'b0010);
    step("rr2", 4'b0100);
    step("rr3", 4'b1000);
    step("rr4", 4'b0001);

    // Only 1 and 3 valid: alternate without bubbles (ptr starts at 1).
    bus.in_valid = 4'b1010;
    step("alt0", 4'b0010);
    step("alt1", 4'b1000);
    step("alt2", 4'b0010);
    step("alt3", 4'b1000);

    // Load c from src 2 (ptr 0 -> 3), then stall three cycles with all valid.
    bus.in_valid = 4'b0100;
    step("ld2", 4'b0100);
    bus.in_valid  = 4'hf;
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step("stall", 4'b0000);
      chk("stall.out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall.out_data",  32'(bus.out_data),  32'hc);
      chk("stall.out_src",   32'(bus.out_src),   32'd2);
    end
    bus.out_ready = 1'b1;
    step("release", 4'b1000);

    // Reach ptr=2 via src 1, then lone requester 0 wins at once; ptr becomes 1.
    bus.in_valid = 4'b0010;
    step("p2", 4'b0010);
    bus.in_valid = 4'b0001;
    step("lone0", 4'b0001);
    bus.in_valid = 4'hf;
    step("after0", 4'b0010);

    // Pop with nothing valid: output empties, data holds.
    bus.in_valid = 4'b0000;
    step("pop", 4'b0000);
    chk("pop.out_valid", 32'(bus.out_valid), 32'd0);
    chk("pop.out_data",  32'(bus.out_data),  32'(last_data));
    chk("pop.out_src",   32'(bus.out_src),   32'(last_src));
    step("idle", 4'b0000);
    chk("idle.out_valid", 32'(bus.out_valid), 32'd0);

    // FULL with src 1 (ptr is 2), then asynchronous reset mid-operation.
    bus.in_valid = 4'b0010;
    step("full1", 4'b0010);
    bus.in_valid = 4'hf;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.out_src",   32'(bus.out_src),   32'd0);
    chk("arst.out_data",  32'(bus.out_data),  32'd0);
    chk("arst.in_ready",  32'(bus.in_ready),  32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("arst.hold_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    step("post_rst0", 4'b0001);
    step("post_rst1", 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
